// File: rtl/data_packer_multi_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_packer_multi_if
// Brief    : Input, output and configuration bus of data_packer_multi.
//            Statistics ports exist only when DATA_PACKER_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
interface data_packer_multi_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CHAINS = 4
);
    localparam int CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
    localparam int COUNT_W = $clog2(N + 1);

    logic                         tracing;
    logic                         valid_in;
    logic                         ready_out;
    logic                         eof_in;
    logic                         bof_in;
    logic [CHAIN_W-1:0]           chainId_in;
    logic [7:0]                   configId;
    logic [7:0]                   configData;
    logic [N-1:0][DATA_WIDTH-1:0] vector_in;
    logic [N-1:0][DATA_WIDTH-1:0] vector_out;
    logic [COUNT_W-1:0]           count_out;
    logic                         valid_out;
    logic                         ready_in;
`ifdef DATA_PACKER_STATS_EN
    logic [31:0]                  stat_vectors_out;
    logic [15:0]                  stat_flushes_out;

    modport master (
        output tracing, valid_in, eof_in, bof_in, chainId_in,
        output configId, configData, vector_in, ready_in,
        input  ready_out, vector_out, count_out, valid_out,
        input  stat_vectors_out, stat_flushes_out
    );

    modport slave (
        input  tracing, valid_in, eof_in, bof_in, chainId_in,
        input  configId, configData, vector_in, ready_in,
        output ready_out, vector_out, count_out, valid_out,
        output stat_vectors_out, stat_flushes_out
    );
`else
    modport master (
        output tracing, valid_in, eof_in, bof_in, chainId_in,
        output configId, configData, vector_in, ready_in,
        input  ready_out, vector_out, count_out, valid_out
    );

    modport slave (
        input  tracing, valid_in, eof_in, bof_in, chainId_in,
        input  configId, configData, vector_in, ready_in,
        output ready_out, vector_out, count_out, valid_out
    );
`endif
endinterface
`default_nettype wire

// File: rtl/data_packer_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_packer_multi
// Brief    : Packs per-chain vectors of N, M or 1 elements into dense
//            N-element outputs with valid/ready backpressure, end-of-frame
//            flush and shift-loaded firmware. Define DATA_PACKER_STATS_EN to
//            add vector/flush statistics counters.
// Revision : 1.0
// ============================================================================
module data_packer_multi #(
    parameter int                     N                  = 8,
    parameter int                     M                  = 2,
    parameter int                     DATA_WIDTH         = 32,
    parameter int                     MAX_CHAINS         = 4,
    parameter logic [7:0]             PERSONAL_CONFIG_ID = 8'd0,
    parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE  = '0
) (
    input  logic               clk,
    input  logic               rst,
    data_packer_multi_if.slave bus
);
    localparam int ACC_N   = 2 * N - 1;
    localparam int FILL_W  = $clog2(N);
    localparam int SUM_W   = $clog2(2 * N);
    localparam int COUNT_W = $clog2(N + 1);

    localparam logic [7:0] FW_FULL = 8'd0;
    localparam logic [7:0] FW_MID  = 8'd1;
    localparam logic [7:0] FW_ONE  = 8'd2;

    typedef logic [DATA_WIDTH-1:0] elem_t;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [FILL_W-1:0]             fill_q, fill_d;
    elem_t                         acc_q [ACC_N];
    elem_t                         acc_d [ACC_N];
    elem_t                         acc_app [ACC_N];
    logic [N-1:0][DATA_WIDTH-1:0]  vector_out_q, vector_out_d;
    logic [COUNT_W-1:0]            count_out_q, count_out_d;
    logic                          valid_out_q, valid_out_d;
    logic [7:0]                    fw_q [MAX_CHAINS];
    logic [7:0]                    fw_d [MAX_CHAINS];

    logic [7:0]                    fw_code;
    logic [COUNT_W-1:0]            len;
    logic [SUM_W-1:0]              base;
    logic [SUM_W-1:0]              sum;
    logic [SUM_W-1:0]              residue;
    logic                          out_free;
    logic                          ready_out;
    logic                          accept;
    logic                          flush_emit;
    logic                          cfg_hit;

    assign out_free   = !valid_out_q || bus.ready_in;
    assign ready_out  = (state_q == ST_ACCUM) && out_free;
    assign accept     = bus.valid_in && bus.tracing && ready_out;
    assign flush_emit = (state_q == ST_FLUSH) && out_free;
    assign cfg_hit    = (bus.configId == PERSONAL_CONFIG_ID);

    // Drop (code 3) and unknown codes both append nothing; they differ only in intent.
    always_comb begin
        fw_code = fw_q[bus.chainId_in];
        case (fw_code)
            FW_FULL: len = COUNT_W'(N);
            FW_MID:  len = COUNT_W'(M);
            FW_ONE:  len = COUNT_W'(1);
            default: len = '0;
        endcase
    end

    always_comb begin
        fw_d = fw_q;
        if (cfg_hit) begin
            for (int i = 0; i < MAX_CHAINS - 1; i++) begin
                fw_d[i] = fw_q[i + 1];
            end
            fw_d[MAX_CHAINS-1] = bus.configData;
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        acc_d        = acc_q;
        acc_app      = acc_q;
        valid_out_d  = valid_out_q;
        vector_out_d = vector_out_q;
        count_out_d  = count_out_q;
        base         = bus.bof_in ? '0 : SUM_W'(fill_q);
        sum          = base + SUM_W'(len);
        residue      = sum;

        if (valid_out_q && bus.ready_in) begin
            valid_out_d = 1'b0;
        end

        if (flush_emit) begin
            // Positions at or above fill may hold stale data; pad them with zero.
            for (int i = 0; i < N; i++) begin
                vector_out_d[i] = (i < int'(fill_q)) ? acc_q[i] : '0;
            end
            count_out_d = COUNT_W'(fill_q);
            valid_out_d = 1'b1;
            fill_d      = '0;
            state_d     = ST_ACCUM;
        end else if (accept) begin
            for (int j = 0; j < N; j++) begin
                if (j < int'(len)) begin
                    acc_app[base + SUM_W'(j)] = bus.vector_in[j];
                end
            end
            if (sum >= SUM_W'(N)) begin
                residue = sum - SUM_W'(N);
                for (int i = 0; i < N; i++) begin
                    vector_out_d[i] = acc_app[i];
                end
                count_out_d = COUNT_W'(N);
                valid_out_d = 1'b1;
                for (int i = 0; i < ACC_N; i++) begin
                    acc_d[i] = '0;
                end
                for (int i = 0; i < N - 1; i++) begin
                    acc_d[i] = acc_app[i + N];
                end
            end else begin
                acc_d = acc_app;
            end
            fill_d = FILL_W'(residue);
            if (bus.eof_in && (residue != '0)) begin
                state_d = ST_FLUSH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ACCUM;
            fill_q       <= '0;
            valid_out_q  <= 1'b0;
            vector_out_q <= '0;
            count_out_q  <= '0;
            for (int i = 0; i < ACC_N; i++) begin
                acc_q[i] <= '0;
            end
            for (int i = 0; i < MAX_CHAINS; i++) begin
                fw_q[i] <= INITIAL_FIRMWARE[8*i +: 8];
            end
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            valid_out_q  <= valid_out_d;
            vector_out_q <= vector_out_d;
            count_out_q  <= count_out_d;
            acc_q        <= acc_d;
            fw_q         <= fw_d;
        end
    end

    assign bus.ready_out  = ready_out;
    assign bus.valid_out  = valid_out_q;
    assign bus.vector_out = vector_out_q;
    assign bus.count_out  = count_out_q;

`ifdef DATA_PACKER_STATS_EN
    localparam logic [7:0] STATS_CLR_ID = PERSONAL_CONFIG_ID + 8'd1;

    logic [31:0] stat_vectors_q, stat_vectors_d;
    logic [15:0] stat_flushes_q, stat_flushes_d;

    always_comb begin
        stat_vectors_d = stat_vectors_q;
        stat_flushes_d = stat_flushes_q;
        if (bus.configId == STATS_CLR_ID) begin
            stat_vectors_d = '0;
            stat_flushes_d = '0;
        end else begin
            if (accept && (len != '0) && (stat_vectors_q != '1)) begin
                stat_vectors_d = stat_vectors_q + 32'd1;
            end
            if (flush_emit && (stat_flushes_q != '1)) begin
                stat_flushes_d = stat_flushes_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_vectors_q <= '0;
            stat_flushes_q <= '0;
        end else begin
            stat_vectors_q <= stat_vectors_d;
            stat_flushes_q <= stat_flushes_d;
        end
    end

    assign bus.stat_vectors_out = stat_vectors_q;
    assign bus.stat_flushes_out = stat_flushes_q;
`endif
endmodule
`default_nettype wire

// File: doc/data_packer_multi.md
Name: data_packer_multi

Overview:
- Successor to the trace-path packer. Packs vectors of N, M or 1 valid elements, selected per chain by firmware, into dense N-element output vectors.
- Packing is exact: a vector that does not fit is split across two outputs rather than forcing an early emit.
- Adds downstream backpressure (valid/ready), end-of-frame flush with an element count, and runtime firmware reconfiguration.
- Sits between the filter/reduce stage and the trace buffer.

Parameters:
- N, 8: output vector width in elements. Must be at least 2.
- M, 2: intermediate granularity. Requires 1 < M < N.
- DATA_WIDTH, 32: element width in bits.
- MAX_CHAINS, 4: number of firmware entries, one per chain.
- PERSONAL_CONFIG_ID, 0: configId value that addresses this block.
- INITIAL_FIRMWARE, all 0: reset contents of the firmware table, 8 bits per chain.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- tracing  in  1  global enable. Input is accepted only while this is 1.
- valid_in  in  1  input vector valid.
- ready_out  out  1  block can accept input this cycle.
- eof_in  in  1  last vector of frame. Qualified by an accepted input.
- bof_in  in  1  first vector of frame. Discards any residue left from the previous frame.
- chainId_in  in  clog2(MAX_CHAINS)  selects the firmware entry.
- configId  in  8  configuration bus id.
- configData  in  8  configuration bus data.
- vector_in  in  N x DATA_WIDTH  input elements. Only elements [L-1:0] are meaningful.
- vector_out  out  N x DATA_WIDTH  packed output. Element 0 is the oldest.
- count_out  out  clog2(N+1)  number of valid elements in vector_out.
- valid_out  out  1  output valid.
- ready_in  in  1  downstream accepts vector_out this cycle.

Behaviour:
- Reset (asynchronous): valid_out=0, count_out=0, vector_out=0, accumulator cleared, fill=0, state=ACCUM, firmware=INITIAL_FIRMWARE.
- Firmware decode per chain: 0 gives L=N, 1 gives L=M, 2 gives L=1, 3 means drop (consumed, no effect), any other value gives L=0 and the vector is ignored.
- Config: in any cycle where configId==PERSONAL_CONFIG_ID, the firmware table shifts one entry toward index 0 and configData is loaded into entry MAX_CHAINS-1. Config writes are independent of tracing and of the data path.
- Accept condition: valid_in && tracing && ready_out.
- ready_out = (state==ACCUM) && (!valid_out || ready_in).
- Accumulator: 2N-1 elements plus a fill counter (0..N-1 between cycles).
  - On accept, the L elements are appended at position fill.
  - If fill+L >= N: the lowest N elements load into vector_out, count_out=N, valid_out=1, remaining fill+L-N elements shift to position 0, fill=fill+L-N.
  - Otherwise fill=fill+L and valid_out is unchanged unless the current output is handed off.
- bof_in on an accepted vector: fill is treated as 0 before appending. Residue is discarded, not emitted.
- Latency: 1 cycle from accept to valid_out.
- Output hold: while valid_out && !ready_in, vector_out and count_out stay stable and ready_out=0.
- Output handoff: valid_out drops on the ready_in handshake unless a new output is loaded in the same cycle.
- State machine, ACCUM to FLUSH:
  - Taken when an accepted vector has eof_in=1 and, after any full emit in the same cycle, the residue is greater than 0.
  - In FLUSH, ready_out=0. When the output register is free, the residue is emitted zero-padded with count_out=residue, then fill=0 and state returns to ACCUM.
  - eof_in with residue 0 produces no extra output and stays in ACCUM.
- Simultaneous full emit and eof: emits two outputs on consecutive free slots. Input stalls for at least 1 cycle.
- tracing=0: no input is accepted. A pending output and FLUSH still complete. fill is retained.
- Reset mid-frame or mid-FLUSH discards everything. No output is produced for residue.

Optional Feature:
- DATA_PACKER_STATS_EN defined: adds output stat_vectors_out (32 bits, accepted input vectors with L>0) and stat_flushes_out (16 bits, partial flush outputs emitted).
  - Both reset to 0 and saturate at their maximum.
  - Both clear when configId==PERSONAL_CONFIG_ID+1.
- Undefined: the ports are absent and there is no counter logic.

Test Plan:
- Firmware all 2, eight accepted vectors with vector_in[0]=1..8, ready_in=1 -> exactly one output, vector_out=1,2,...,8, count_out=8, one cycle after the 8th accept.
- Firmware 1 (M=2), five vectors {1,2},{3,4},{5,6},{7,8},{9,10} with eof on the fifth -> outputs 1..8 (count 8), then 9,10,0,0,0,0,0,0 (count 2). ready_out is low for 1 cycle.
- Chain 0 = code 1, chain 1 = code 0: three M-vectors {1,2},{3,4},{5,6}, then an N-vector 11..18 -> output 1..6,11,12 (count 8), fill=6 holding 13..18.
- ready_in=0 for 5 cycles while an output is pending -> vector_out is stable, ready_out=0, no input is consumed. Release -> handoff happens in 1 cycle.
- Three config writes 2,1,0 with id=PERSONAL_CONFIG_ID at MAX_CHAINS=4 -> firmware table becomes {INIT[3],2,1,0}. chainId 3 then uses L=N.
- rst pulsed during FLUSH with residue 3 -> valid_out=0 immediately, the next frame starts with fill=0, and no stale elements appear.
